// File: rtl/lector_7seg_mux_pkg.sv
// Shared 7-segment definitions (active low {a..g}) and the capture FSM encoding.
// Pattern decode is purely combinational.
package lector_7seg_mux_pkg;

  localparam logic [6:0] SEG_0      = 7'b0000001;
  localparam logic [6:0] SEG_1      = 7'b1001111;
  localparam logic [6:0] SEG_2      = 7'b0010010;
  localparam logic [6:0] SEG_3      = 7'b0000110;
  localparam logic [6:0] SEG_4      = 7'b1001100;
  localparam logic [6:0] SEG_5      = 7'b0100100;
  localparam logic [6:0] SEG_6      = 7'b0100000;
  localparam logic [6:0] SEG_7      = 7'b0001111;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0000100;
  localparam logic [6:0] SEG_A      = 7'b0001000;
  localparam logic [6:0] SEG_B      = 7'b1100000;
  localparam logic [6:0] SEG_C      = 7'b0110001;
  localparam logic [6:0] SEG_D      = 7'b1000010;
  localparam logic [6:0] SEG_E      = 7'b0110000;
  localparam logic [6:0] SEG_F      = 7'b0111000;
  localparam logic [6:0] SEG_BLANCO = 7'b1111111;

  typedef enum logic [1:0] {
    ESPERA,
    ESTABILIZA,
    CAPTURADO
  } estado_t;

  typedef struct packed {
    logic       invalido;
    logic       blanco;
    logic [3:0] nibble;
  } digito_t;

  // Blank and unrecognised patterns both report nibble 0.
  function automatic digito_t decodifica(input logic [6:0] seg);
    digito_t d;
    d = '{invalido: 1'b0, blanco: 1'b0, nibble: 4'h0};
    case (seg)
      SEG_0:      d.nibble = 4'h0;
      SEG_1:      d.nibble = 4'h1;
      SEG_2:      d.nibble = 4'h2;
      SEG_3:      d.nibble = 4'h3;
      SEG_4:      d.nibble = 4'h4;
      SEG_5:      d.nibble = 4'h5;
      SEG_6:      d.nibble = 4'h6;
      SEG_7:      d.nibble = 4'h7;
      SEG_8:      d.nibble = 4'h8;
      SEG_9:      d.nibble = 4'h9;
      SEG_A:      d.nibble = 4'hA;
      SEG_B:      d.nibble = 4'hB;
      SEG_C:      d.nibble = 4'hC;
      SEG_D:      d.nibble = 4'hD;
      SEG_E:      d.nibble = 4'hE;
      SEG_F:      d.nibble = 4'hF;
      SEG_BLANCO: d.blanco = 1'b1;
      default:    d.invalido = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lector_7seg_mux_sincronizador_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Latency 2 cycles; no flow control.
module sincronizador_2ff #(
  parameter int ANCHO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] d,
  output logic [ANCHO-1:0] q
);

  logic [ANCHO-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lector_7seg_mux.sv
// Recovers the hex digits shown on a multiplexed 7-segment display, one frame per o_valido pulse.
// Latency input-to-capture 2 + ESTABLE cycles; the display cannot be stalled, so there is no backpressure.
module lector_7seg_mux
  import lector_7seg_mux_pkg::*;
#(
  parameter int N_DIGITOS = 4,
  parameter int ESTABLE   = 8,
  parameter int TIMEOUT   = 100000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [6:0]             i_segmentos,
  input  logic [N_DIGITOS-1:0]   i_anodos,
  input  logic                   i_habilita,
  output logic [4*N_DIGITOS-1:0] o_valor,
  output logic [N_DIGITOS-1:0]   o_blanco,
  output logic                   o_valido,
  output logic                   o_error,
  output logic                   o_sin_senal
);

  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CNT_W = $clog2(ESTABLE + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic [6:0]             seg_s;
  logic [N_DIGITOS-1:0]   an_s;

  sincronizador_2ff #(.ANCHO(7)) u_sync_seg (
    .clk(i_clk), .rst(i_rst), .d(i_segmentos), .q(seg_s)
  );

  sincronizador_2ff #(.ANCHO(N_DIGITOS)) u_sync_an (
    .clk(i_clk), .rst(i_rst), .d(i_anodos), .q(an_s)
  );

  logic [IDX_W-1:0] idx;
  logic [3:0]       n_bajos;
  logic             dig_vld;

  always_comb begin
    idx     = '0;
    n_bajos = '0;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (!an_s[k]) begin
        idx     = IDX_W'(k);
        n_bajos = n_bajos + 4'd1;
      end
    end
    dig_vld = (n_bajos == 4'd1);
  end

  estado_t                estado;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx_l;
  logic [6:0]             pat_l;
  logic [N_DIGITOS-1:0]   mascara;
  logic [4*N_DIGITOS-1:0] stg_valor;
  logic [N_DIGITOS-1:0]   stg_blanco;
  logic                   stg_error;
  logic [TO_W-1:0]        cnt_to;

  logic    mismo;
  logic    guarda;
  logic    completo;
  digito_t dec;

  assign mismo    = dig_vld && (idx == idx_l) && (seg_s == pat_l);
  assign guarda   = (estado == ESTABILIZA) && i_habilita && mismo &&
                    (cnt == CNT_W'(ESTABLE - 1));
  assign completo = &mascara;
  assign dec      = decodifica(pat_l);

  assign o_sin_senal = (cnt_to == TO_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      estado     <= ESPERA;
      cnt        <= '0;
      idx_l      <= '0;
      pat_l      <= '0;
      mascara    <= '0;
      stg_valor  <= '0;
      stg_blanco <= '0;
      stg_error  <= 1'b0;
      cnt_to     <= '0;
      o_valor    <= '0;
      o_blanco   <= '0;
      o_valido   <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_valido <= 1'b0;

      if (!i_habilita) begin
        estado <= ESPERA;
      end else begin
        case (estado)
          ESPERA: begin
            if (dig_vld) begin
              estado <= ESTABILIZA;
              cnt    <= CNT_W'(1);
              idx_l  <= idx;
              pat_l  <= seg_s;
            end
          end
          ESTABILIZA: begin
            if (!mismo)      estado <= ESPERA;
            else if (guarda) estado <= CAPTURADO;
            else             cnt    <= cnt + CNT_W'(1);
          end
          CAPTURADO: begin
            // A pattern change on the same anode is not a new digit.
            if (!dig_vld || idx != idx_l) estado <= ESPERA;
          end
          default: estado <= ESPERA;
        endcase
      end

      if (completo) begin
        o_valor   <= stg_valor;
        o_blanco  <= stg_blanco;
        o_error   <= stg_error;
        o_valido  <= 1'b1;
        mascara   <= '0;
        stg_error <= 1'b0;
      end

      if (guarda) begin
        stg_valor[4*idx_l +: 4] <= dec.nibble;
        stg_blanco[idx_l]       <= dec.blanco;
        stg_error               <= (stg_error & ~completo) | dec.invalido;
        mascara[idx_l]          <= 1'b1;
        cnt_to                  <= '0;
      end else if (cnt_to != TO_W'(TIMEOUT)) begin
        cnt_to <= cnt_to + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lector_7seg_mux.sv
// Directed bench for lector_7seg_mux: table of 4-digit frames plus glitch, timeout and reset sequences.
module tb_lector_7seg_mux;

  localparam int ND  = 4;
  localparam int EST = 8;
  localparam int TO  = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          hab;
  logic [15:0]   o_valor;
  logic [3:0]    o_blanco;
  logic          o_valido;
  logic          o_error;
  logic          o_sin_senal;

  lector_7seg_mux #(.N_DIGITOS(ND), .ESTABLE(EST), .TIMEOUT(TO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_segmentos(seg),
    .i_anodos(an),
    .i_habilita(hab),
    .o_valor(o_valor),
    .o_blanco(o_blanco),
    .o_valido(o_valido),
    .o_error(o_error),
    .o_sin_senal(o_sin_senal)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int ok     = 0;
  int pulsos = 0;

  // Counts every cycle o_valido is high, so a stretched pulse shows up as extra pulses.
  always @(negedge clk) if (o_valido === 1'b1) pulsos++;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [15:0]     valor;
    logic [3:0]      blanco;
    logic            err;
  } vec_t;

  vec_t tabla[5];

  task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) ok++;
    else $display("FAIL %s: got %0h expected %0h", nom, act, exp);
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digito(input int k, input logic [6:0] p, input int n);
    an    = '1;
    an[k] = 1'b0;
    seg   = p;
    ciclos(n);
  endtask

  task automatic reposo(input int n);
    an  = '1;
    seg = 7'b1111111;
    ciclos(n);
  endtask

  int p0;

  initial begin
    // Digit order inside each seg field is {d3, d2, d1, d0}.
    tabla[0] = '{seg: {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111},
                 valor: 16'h4321, blanco: 4'b0000, err: 1'b0};
    tabla[1] = '{seg: {7'b0110001, 7'b1111110, 7'b1100000, 7'b0001000},
                 valor: 16'hC0BA, blanco: 4'b0000, err: 1'b1};
    tabla[2] = '{seg: {7'b1111111, 7'b1000010, 7'b0110000, 7'b0111000},
                 valor: 16'h0DEF, blanco: 4'b1000, err: 1'b0};
    tabla[3] = '{seg: {7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100},
                 valor: 16'h6789, blanco: 4'b0000, err: 1'b0};
    tabla[4] = '{seg: {7'b0111000, 7'b0001111, 7'b0100100, 7'b0000001},
                 valor: 16'hF750, blanco: 4'b0000, err: 1'b0};

    rst = 1'b1;
    hab = 1'b1;
    an  = '1;
    seg = 7'b1111111;
    ciclos(3);
    rst = 1'b0;
    ciclos(1);
    chk("reset valor", 32'(o_valor), 32'h0);
    chk("reset blanco", 32'(o_blanco), 32'h0);
    chk("reset valido", 32'(o_valido), 32'h0);
    chk("reset error", 32'(o_error), 32'h0);
    chk("reset sin_senal", 32'(o_sin_senal), 32'h0);

    for (int i = 0; i < 5; i++) begin
      p0 = pulsos;
      for (int k = 0; k < ND; k++) digito(k, tabla[i].seg[k], 20);
      reposo(5);
      chk($sformatf("vec%0d pulsos", i), 32'(pulsos - p0), 32'd1);
      chk($sformatf("vec%0d valor", i), 32'(o_valor), 32'(tabla[i].valor));
      chk($sformatf("vec%0d blanco", i), 32'(o_blanco), 32'(tabla[i].blanco));
      chk($sformatf("vec%0d error", i), 32'(o_error), 32'(tabla[i].err));
    end

    // A 5 held for one sample short of ESTABLE must never be stored.
    p0 = pulsos;
    digito(0, 7'b0100100, EST - 1);
    digito(0, 7'b0000000, 20);
    digito(1, 7'b1001111, 20);
    digito(2, 7'b0010010, 20);
    digito(3, 7'b0000110, 20);
    reposo(5);
    chk("glitch pulsos", 32'(pulsos - p0), 32'd1);
    chk("glitch valor", 32'(o_valor), 32'h3218);

    p0  = pulsos;
    an  = 4'b0000;
    seg = 7'b1001111;
    ciclos(500);
    chk("multihot sin_senal early", 32'(o_sin_senal), 32'h0);
    ciclos(600);
    chk("multihot sin_senal late", 32'(o_sin_senal), 32'h1);
    chk("multihot pulsos", 32'(pulsos - p0), 32'd0);
    chk("timeout valor held", 32'(o_valor), 32'h3218);

    hab = 1'b0;
    digito(0, 7'b0100100, 200);
    chk("habilita0 sin_senal", 32'(o_sin_senal), 32'h1);
    chk("habilita0 pulsos", 32'(pulsos - p0), 32'd0);
    hab = 1'b1;
    digito(0, 7'b0100100, 20);
    chk("store clears sin_senal", 32'(o_sin_senal), 32'h0);
    digito(1, 7'b1001111, 20);
    digito(2, 7'b0010010, 20);
    digito(3, 7'b0000110, 20);
    reposo(5);
    chk("after timeout pulsos", 32'(pulsos - p0), 32'd1);
    chk("after timeout valor", 32'(o_valor), 32'h3215);

    // Partial frame on digits 0,1, then reset; next frame starts with digits 2,3.
    digito(0, 7'b1001111, 20);
    digito(1, 7'b0010010, 20);
    p0  = pulsos;
    rst = 1'b1;
    ciclos(2);
    rst = 1'b0;
    chk("midreset valor", 32'(o_valor), 32'h0);
    chk("midreset sin_senal", 32'(o_sin_senal), 32'h0);
    digito(2, 7'b0001111, 20);
    digito(3, 7'b0100000, 20);
    chk("midreset no early frame", 32'(pulsos - p0), 32'd0);
    digito(0, 7'b0000100, 20);
    digito(1, 7'b0000000, 20);
    reposo(5);
    chk("midreset pulsos", 32'(pulsos - p0), 32'd1);
    chk("midreset frame valor", 32'(o_valor), 32'h6789);
    chk("midreset frame error", 32'(o_error), 32'h0);

    $display("%0d/%0d checks passed", ok, total);
    $finish;
  end

endmodule

// File: doc/lector_7seg_mux.md
Name: lector_7seg_mux

Overview:
- Reverse direction of the team's binary-to-7-segment decoder. Observes the segment and anode lines of an external multiplexed 7-segment display and recovers the hex nibble shown on each digit.
- Publishes a complete multi-digit frame with a one-cycle valid pulse.
- Used as a display monitor/self-check and for reading instruments that only expose a 7-seg display.

Parameters:
- N_DIGITOS, 4, number of multiplexed digits, range 1..8.
- ESTABLE, 8, consecutive identical samples required before a digit is accepted, ≥2.
- TIMEOUT, 100000, cycles without any accepted digit before o_sin_senal asserts.

Ports:
- i_clk  in  1  system clock (single clock domain).
- i_rst  in  1  synchronous, active-high reset.
- i_segmentos  in  7  segment lines {a,b,c,d,e,f,g}, active low, asynchronous to i_clk.
- i_anodos  in  N_DIGITOS  digit enables, active low, asynchronous; bit k = digit k (k=0 is least significant).
- i_habilita  in  1  capture enable.
- o_valor  out  4*N_DIGITOS  last complete frame; nibble k = digit k.
- o_blanco  out  N_DIGITOS  digit k was blank (1111111) in last frame.
- o_valido  out  1  one-cycle pulse when o_valor/o_blanco/o_error update.
- o_error  out  1  last frame contained an unrecognised pattern.
- o_sin_senal  out  1  level; no digit accepted for TIMEOUT cycles.

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0; synchronizers, counters, capture mask and FSM cleared. i_rst wins over every other event.
- Input sync: i_segmentos and i_anodos each pass through 2 flops. All logic below uses the synced values. Input-to-capture latency = 2 + ESTABLE cycles.
- Anode decode: exactly one low bit gives a valid digit index. All-high or multi-low gives no digit.
- Segment encode, active low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111.
  - Any other pattern is invalid.
- FSM states ESPERA, ESTABILIZA, CAPTURADO:
  - ESPERA: valid digit and i_habilita=1 → ESTABILIZA; counter=1; latch index and pattern.
  - ESTABILIZA: index and pattern unchanged → counter+1. When counter reaches ESTABLE: store the digit, then → CAPTURADO. Any change in index or pattern → ESPERA; nothing stored.
  - CAPTURADO: stays until the index changes or no digit is selected, then → ESPERA. The same digit is never captured twice per anode dwell.
  - i_habilita=0 in any state → ESPERA next cycle. Capture mask and staging data are kept.
- Store digit k:
  - Write nibble (invalid or blank → 0) into staging.
  - Set blank bit k; OR the invalid flag into the staging error.
  - Set mask bit k. Recapturing a digit already in the mask overwrites its staging data.
- Frame complete: mask all ones on the cycle after a store. Then:
  - Copy staging to o_valor/o_blanco/o_error.
  - Pulse o_valido for 1 cycle.
  - Clear mask and staging error.
  - Digit order is irrelevant.
- Timeout counter:
  - Reset to 0 on every store; saturates at TIMEOUT.
  - o_sin_senal = (counter == TIMEOUT).
  - Deasserts on the cycle after the next store.
  - o_valor holds its last value.
- Reset mid-frame discards the partial frame; no o_valido pulse.

Decomposition:
- Shared package holds:
  - the 16 active-low segment constants plus SEG_BLANCO, also used by the existing decoder;
  - the FSM state encoding;
  - a function mapping 7-bit pattern → {invalid, blank, nibble[3:0]}.
- One natural sub-module: sincronizador_2ff, parameterised width, reused for both input buses.

Test Plan:
- Reset, then drive digits 0..3 = 1,2,3,4: segments 1001111, 0010010, 0000110, 1001100, each anode held 20 cycles → one o_valido pulse; o_valor=16'h4321, o_blanco=0, o_error=0.
- Glitch: digit 0 shows 0100100 for ESTABLE-1 cycles, then 0000000 for 20 cycles → digit 0 = 8; the 5 is never stored.
- Invalid pattern 1111110 on digit 2 (others valid: A, b, C) → o_error=1; nibble 2 = 0; next clean frame clears o_error.
- Blank 1111111 on digit 3 with digits 0..2 = F, E, d → o_blanco=4'b1000; o_valor=16'h0DEF.
- Multi-hot anodes (4'b0000) or i_habilita=0 for 5000 cycles → no store, no o_valido. With TIMEOUT=1000 → o_sin_senal=1 after 1000 cycles; clears after the next store.
- Assert i_rst after 2 of 4 digits are captured, then run a full frame of 9,8,7,6 → exactly one o_valido; o_valor=16'h6789.
